// File: rtl/gradient_map_pkg.sv
// Shared definitions for the EVT2.0-over-UART transmit path.
// Contents:
//   EVT_WORD_W          width of one EVT2.0 word
//   UART_DATA_BITS      data bits per UART frame (8N1)
//   EVT_BYTES_PER_WORD  UART bytes per EVT2.0 word
//   tx_state_t          sequencer / byte shifter state encoding
package gradient_map_pkg;
   localparam int EVT_WORD_W         = 32;
   localparam int UART_DATA_BITS     = 8;
   localparam int EVT_BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } tx_state_t;
endpackage

// File: rtl/evt2_uart_tx_serializer_if.sv
// Word handshake between an EVT2.0 word source and the UART serializer.
// Signals:
//   evt_word   32-bit EVT2.0 word (source -> serializer)
//   evt_valid  evt_word valid       (source -> serializer)
//   evt_ready  serializer can take a word (serializer -> source)
// Modports: master = word source, slave = serializer.
interface evt2_uart_tx_serializer_if;
   import gradient_map_pkg::*;

   logic [EVT_WORD_W-1:0] evt_word;
   logic                  evt_valid;
   logic                  evt_ready;

   modport master (output evt_word, output evt_valid, input evt_ready);
   modport slave  (input evt_word, input evt_valid, output evt_ready);
endinterface

// File: rtl/evt2_uart_byte_tx.sv
// 8N1 byte shifter: start bit, 8 data bits LSB first, one stop bit, each
// CLKS_PER_BIT clocks long.
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset; line returns high on that edge
//   byte_valid  byte_data offered; taken when byte_ready
//   byte_ready  shifter idle
//   byte_data   byte to send
//   tx          serial line (flop driven, idle high)
//   byte_end    last clock of the stop bit; the shifter is idle after this edge
module evt2_uart_byte_tx
   import gradient_map_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      byte_valid,
   output logic                      byte_ready,
   input  logic [UART_DATA_BITS-1:0] byte_data,
   output logic                      tx,
   output logic                      byte_end
);
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

   tx_state_t                 state;
   logic [CNT_W-1:0]          cnt;
   logic [BIT_W-1:0]          bit_idx;
   logic [UART_DATA_BITS-1:0] data_reg;

   assign byte_ready = (state == IDLE);
   assign byte_end   = (state == STOP) && (cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         data_reg <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (byte_valid) begin
                  data_reg <= byte_data;
                  tx       <= 1'b0;
                  cnt      <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (cnt == CNT_MAX) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx      <= data_reg[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_MAX) begin
                  cnt <= '0;
                  if (bit_idx == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     // data_reg is shifted so the next bit is always at [1]
                     bit_idx  <= bit_idx + 1'b1;
                     tx       <= data_reg[1];
                     data_reg <= data_reg >> 1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_MAX) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: rtl/evt2_uart_tx_serializer.sv
// EVT2.0 word -> UART serializer. Buffers words in a small FIFO and sends
// each as 4 UART 8N1 bytes, most significant byte first.
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   evt         word handshake (slave side): evt_word/evt_valid/evt_ready
//   uart_tx     serial line, idle high
//   tx_busy     sequencer active or FIFO non-empty
//   word_done   1-cycle pulse when the 4th byte's stop bit ends
//   fifo_full   FIFO full (debug)
//   fifo_empty  FIFO empty (debug)
// FIFO_DEPTH must be a power of two, >= 2.
module evt2_uart_tx_serializer
   import gradient_map_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 12_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   evt2_uart_tx_serializer_if.slave    evt,
   output logic                        uart_tx,
   output logic                        tx_busy,
   output logic                        word_done,
   output logic                        fifo_full,
   output logic                        fifo_empty
);
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int BYTE_W       = $clog2(EVT_BYTES_PER_WORD);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(EVT_BYTES_PER_WORD - 1);

   // ---------------- word FIFO ----------------
   logic [EVT_WORD_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  push;
   logic                  pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign evt.evt_ready = !fifo_full;
   assign push          = evt.evt_valid && !fifo_full;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= evt.evt_word;
      end
   end

   // ---------------- word/byte sequencer ----------------
   // While the byte shifter owns the line (its START/DATA/STOP) the
   // sequencer waits in DATA for byte_end.
   tx_state_t             state;
   logic [BYTE_W-1:0]     byte_idx;
   logic [EVT_WORD_W-1:0] word_reg;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  byte_end;
   logic [UART_DATA_BITS-1:0] byte_data;

   // Pop on leaving IDLE, or on the last stop-bit clock of a word so the
   // next word goes straight to LOAD with no extra gap.
   assign pop = !fifo_empty &&
                ((state == IDLE) ||
                 ((state == DATA) && byte_end && (byte_idx == LAST_BYTE)));

   assign byte_valid = (state == LOAD);
   assign byte_data  = word_reg[(EVT_BYTES_PER_WORD - 1 - int'(byte_idx)) * UART_DATA_BITS +: UART_DATA_BITS];
   assign tx_busy    = (state != IDLE) || !fifo_empty;

   // Registered read of the FIFO head.
   always_ff @(posedge clk) begin
      if (pop) begin
         word_reg <= fifo_mem[rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         state     <= IDLE;
         byte_idx  <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  byte_idx <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (byte_ready) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (byte_end) begin
                  if (byte_idx == LAST_BYTE) begin
                     word_done <= 1'b1;
                     byte_idx  <= '0;
                     state     <= fifo_empty ? IDLE : LOAD;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     state    <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   evt2_uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_tx (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_data  (byte_data),
      .tx         (uart_tx),
      .byte_end   (byte_end)
   );
endmodule

// File: tb/tb_evt2_uart_tx_serializer.sv
// Bench for evt2_uart_tx_serializer: one instance at default baud, one at
// 1 Mbaud for the long streaming scenarios. A line decoder rebuilds bytes
// from uart_tx and a word scoreboard holds every accepted word in order.
module tb_evt2_uart_tx_serializer;
   import gradient_map_pkg::*;

   localparam int C_D = 12_000_000 / 115200;     // 104
   localparam int C_F = 12_000_000 / 1_000_000;  // 12

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic tx_d, busy_d, wd_d, full_d, empty_d;
   logic tx_f, busy_f, wd_f, full_f, empty_f;

   evt2_uart_tx_serializer_if if_d ();
   evt2_uart_tx_serializer_if if_f ();

   evt2_uart_tx_serializer u_dut_d (
      .clk(clk), .rst_n(rst_n), .evt(if_d), .uart_tx(tx_d), .tx_busy(busy_d),
      .word_done(wd_d), .fifo_full(full_d), .fifo_empty(empty_d));

   evt2_uart_tx_serializer #(.BAUD_RATE(1_000_000)) u_dut_f (
      .clk(clk), .rst_n(rst_n), .evt(if_f), .uart_tx(tx_f), .tx_busy(busy_f),
      .word_done(wd_f), .fifo_full(full_f), .fifo_empty(empty_f));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic line(input bit fast);
      return fast ? tx_f : tx_d;
   endfunction

   // Waits for a start bit, then samples every clock of the 10 bit slots.
   // nu counts samples that differ from the first sample of their slot.
   task automatic rx_byte(input bit fast, input int timeout, output logic [7:0] b,
                          output int start, output int nu, output bit frame_ok, output bit to);
      int c;
      logic v;
      logic first;
      logic [9:0] slot;
      c = fast ? C_F : C_D;
      to = 1'b1; b = '0; start = 0; nu = 0; frame_ok = 1'b0; slot = '0; first = 1'b0;
      for (int t = 0; t < timeout; t++) begin
         @(negedge clk);
         if (line(fast) === 1'b0) begin
            to = 1'b0;
            break;
         end
      end
      if (to) return;
      start = cyc;
      for (int s = 0; s < 10; s++) begin
         for (int k = 0; k < c; k++) begin
            if (s != 0 || k != 0) @(negedge clk);
            v = line(fast);
            if (k == 0) begin
               first   = v;
               slot[s] = v;
            end else if (v !== first) begin
               nu++;
            end
         end
      end
      b = slot[8:1];
      frame_ok = (slot[0] === 1'b0) && (slot[9] === 1'b1);
   endtask

   // Background decoder for the fast instance.
   logic [7:0] mb_q[$];
   int         ms_q[$];
   int         mnu_q[$];
   bit         mok_q[$];
   int         wdf_q[$];
   int         wdd_q[$];
   bit         mon_en = 1'b0;

   initial begin
      logic [7:0] b;
      int s, nu;
      bit ok, to;
      forever begin
         rx_byte(1'b1, 2000, b, s, nu, ok, to);
         if (!to && mon_en) begin
            mb_q.push_back(b);
            ms_q.push_back(s);
            mnu_q.push_back(nu);
            mok_q.push_back(ok);
         end
      end
   end

   always @(negedge clk) begin
      if (wd_f && mon_en) wdf_q.push_back(cyc);
      if (wd_d) wdd_q.push_back(cyc);
   end

   logic [31:0] sb_q[$];

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic push_word(input bit fast, input logic [31:0] w, input int timeout,
                            output bit ok, output int acc);
      ok = 1'b0; acc = -1;
      if (fast) begin if_f.evt_valid = 1'b1; if_f.evt_word = w; end
      else      begin if_d.evt_valid = 1'b1; if_d.evt_word = w; end
      for (int t = 0; t < timeout; t++) begin
         if (fast ? if_f.evt_ready : if_d.evt_ready) begin
            @(posedge clk); #1;
            ok = 1'b1; acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (fast && ok) sb_q.push_back(w);
   endtask

   task automatic drop_valid();
      if_f.evt_valid = 1'b0;
      if_d.evt_valid = 1'b0;
   endtask

   // Checks the fast-instance stream against the scoreboard, then clears.
   task automatic drain(input string tag, input int nw, input bit b2b);
      int t;
      int bad_gap, bad_nu, bad_frame, bad_wd;
      logic [31:0] got, exp;
      t = 0;
      while (mb_q.size() < 4 * nw && t < nw * 600 + 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_bytes"}, mb_q.size(), 4 * nw);
      chk({tag, "_word_done_count"}, wdf_q.size(), nw);
      bad_gap = 0; bad_nu = 0; bad_frame = 0; bad_wd = 0;
      for (int i = 0; i < ms_q.size(); i++) begin
         bad_nu += mnu_q[i];
         if (!mok_q[i]) bad_frame++;
         // 10 bit periods plus the one idle LOAD cycle between byte starts
         if (b2b && i > 0 && ms_q[i] - ms_q[i-1] != 10 * C_F + 1) bad_gap++;
      end
      for (int k = 0; k < wdf_q.size(); k++) begin
         if (4 * k + 3 < ms_q.size() && wdf_q[k] != ms_q[4*k+3] + 10 * C_F) bad_wd++;
         if (b2b && k > 0 && wdf_q[k] - wdf_q[k-1] != 40 * C_F + 4) bad_wd++;
      end
      chk({tag, "_bit_period_violations"}, bad_nu, 0);
      chk({tag, "_frame_errors"}, bad_frame, 0);
      chk({tag, "_byte_gap_errors"}, bad_gap, 0);
      chk({tag, "_word_done_timing_errors"}, bad_wd, 0);
      for (int k = 0; k < nw; k++) begin
         got = 'x;
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
         if (mb_q.size() >= 4) begin
            got[31:24] = mb_q.pop_front();
            got[23:16] = mb_q.pop_front();
            got[15:8]  = mb_q.pop_front();
            got[7:0]   = mb_q.pop_front();
         end
         chk($sformatf("%s_word%0d", tag, k), got, exp);
      end
      mb_q.delete(); ms_q.delete(); mnu_q.delete(); mok_q.delete();
      wdf_q.delete(); sb_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   logic [7:0]  b;
   int          st[4];
   int          nu, acc, a6[6], e_pop, t, tgt;
   bit          ok, fok, to;
   logic [31:0] w, w6[6];

   initial begin
      rst_n = 1'b0;
      if_d.evt_valid = 1'b0; if_d.evt_word = '0;
      if_f.evt_valid = 1'b0; if_f.evt_word = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("rst_uart_tx", tx_d, 1);
      chk("rst_evt_ready", if_d.evt_ready, 1);
      chk("rst_tx_busy", busy_d, 0);
      chk("rst_word_done", wd_d, 0);
      chk("rst_fifo_full", full_d, 0);
      chk("rst_fifo_empty", empty_d, 1);
      chk("rst_fast_uart_tx", tx_f, 1);
      mon_en = 1'b1;

      // ---- default baud, single word 0xA1B2C3D4 ----
      @(posedge clk); #1;
      w = 32'hA1B2_C3D4;
      push_word(1'b0, w, 10, ok, acc);
      drop_valid();
      chk("d_accept", ok, 1);
      chk("d_busy_after_accept", busy_d, 1);
      for (int i = 0; i < 4; i++) begin
         rx_byte(1'b0, 3000, b, st[i], nu, fok, to);
         chk($sformatf("d_byte%0d_timeout", i), to, 0);
         chk($sformatf("d_byte%0d", i), b, (w >> (24 - 8 * i)) & 32'hFF);
         chk($sformatf("d_byte%0d_period", i), nu, 0);
         chk($sformatf("d_byte%0d_frame", i), fok, 1);
         if (i == 0) chk("d_busy_mid", busy_d, 1);
      end
      chk("d_start_latency", st[0] - acc, 2);
      chk("d_span_4_bytes", st[3] - st[0], 3 * (10 * C_D + 1));
      t = 0;
      while (wdd_q.size() == 0 && t < 50) begin @(negedge clk); t++; end
      chk("d_word_done_at_stop_end", (wdd_q.size() > 0) ? wdd_q[0] : -1, st[3] + 10 * C_D);
      @(negedge clk);
      chk("d_busy_dropped", busy_d, 0);
      repeat (20) @(negedge clk);
      chk("d_word_done_pulses", wdd_q.size(), 1);

      // ---- fast: hold valid with 6 distinct words ----
      @(posedge clk); #1;
      w = $urandom;
      for (int i = 0; i < 6; i++) w6[i] = w + 32'h0101_0101 * i;
      for (int i = 0; i < 5; i++) begin
         push_word(1'b1, w6[i], 5, ok, a6[i]);
         chk($sformatf("h_accept%0d", i), ok, 1);
      end
      chk("h_5_consecutive", a6[4] - a6[0], 4);
      chk("h_full_after_5", full_f, 1);
      chk("h_ready_low", if_f.evt_ready, 0);
      push_word(1'b1, w6[5], 2000, ok, a6[5]);
      drop_valid();
      chk("h_accept5", ok, 1);
      // ready comes back right after word 1's final stop exit (the word_done edge)
      t = 0;
      while (wdf_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
      chk("h_ready_reassert", a6[5] - 1, (wdf_q.size() > 0) ? wdf_q[0] : -1);
      drain("hold", 6, 1'b1);

      // ---- fast: 64 random words loopback, back-to-back ----
      @(posedge clk); #1;
      for (int i = 0; i < 64; i++) begin
         push_word(1'b1, $urandom, 2000, ok, acc);
         if (!ok) chk("lb_push_timeout", ok, 1);
      end
      drop_valid();
      drain("loop", 64, 1'b1);

      // ---- fast: push and pop on the same edge at 2 entries ----
      @(posedge clk); #1;
      push_word(1'b1, $urandom, 5, ok, acc);
      push_word(1'b1, $urandom, 5, ok, acc);
      push_word(1'b1, $urandom, 5, ok, acc);
      drop_valid();
      t = 0;
      while (ms_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
      // word 1's last stop bit ends 3 byte slots plus 10 bit periods after its first start bit
      e_pop = ((ms_q.size() > 0) ? ms_q[0] : 0) + 3 * (10 * C_F + 1) + 10 * C_F;
      @(posedge clk); #1;
      t = 0;
      while (cyc < e_pop - 1 && t < 1000) begin @(posedge clk); #1; t++; end
      w = $urandom;
      if_f.evt_valid = 1'b1; if_f.evt_word = w;
      chk("pp_ready_before", if_f.evt_ready, 1);
      @(posedge clk); #1;
      sb_q.push_back(w);
      chk("pp_pop_same_edge", wd_f, 1);
      chk("pp_not_full", full_f, 0);
      chk("pp_not_empty", empty_f, 0);
      push_word(1'b1, $urandom, 1, ok, acc);
      chk("pp_push5_edge", acc, e_pop + 1);
      chk("pp_full_at_3", full_f, 0);
      push_word(1'b1, $urandom, 1, ok, acc);
      chk("pp_push6_edge", acc, e_pop + 2);
      chk("pp_full_at_4", full_f, 1);
      drop_valid();
      drain("pushpop", 6, 1'b1);

      // ---- fast: reset in the middle of byte 2's data bits ----
      @(posedge clk); #1;
      push_word(1'b1, $urandom, 5, ok, acc);
      push_word(1'b1, $urandom, 5, ok, acc);
      drop_valid();
      t = 0;
      while (ms_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
      tgt = ((ms_q.size() > 0) ? ms_q[0] : 0) + (10 * C_F + 1) + C_F + 4 * C_F;
      @(posedge clk); #1;
      t = 0;
      while (cyc < tgt && t < 1000) begin @(posedge clk); #1; t++; end
      chk("r_queued_before", empty_f, 0);
      chk("r_line_low_data", tx_f, (busy_f === 1'b1) ? tx_f : 1'bx);
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("r_uart_tx", tx_f, 1);
      chk("r_fifo_empty", empty_f, 1);
      chk("r_evt_ready", if_f.evt_ready, 1);
      chk("r_word_done", wd_f, 0);
      chk("r_tx_busy", busy_f, 0);
      repeat (10 * C_F + 10) @(posedge clk);
      #1;
      mb_q.delete(); ms_q.delete(); mnu_q.delete(); mok_q.delete();
      wdf_q.delete(); sb_q.delete();
      mon_en = 1'b1;
      push_word(1'b1, $urandom, 5, ok, acc);
      drop_valid();
      drain("after_rst", 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
